// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between two valid/ready requesters.
// Only one transaction is in flight at a time. Operands, op select and results are registered.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_op1,
    input  logic [WIDTH-1:0] req0_op2,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_op1,
    input  logic [WIDTH-1:0] req1_op2,
    input  logic [SEL_W-1:0] req1_sel,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_res,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_res,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_res
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_op1_q, alu_op1_d;
    logic [WIDTH-1:0] alu_op2_q, alu_op2_d;
    logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [WIDTH-1:0] rsp0_res_q, rsp0_res_d;
    logic [WIDTH-1:0] rsp1_res_q, rsp1_res_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;

    logic grant_valid;
    logic grant_port;
    logic accept;
    logic rsp_handshake;

    // On contention the port that did not win last time gets the grant.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_port  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        accept      = (state_q == IDLE) && grant_valid;
        rsp_handshake = owner_q ? (rsp1_valid_q && rsp1_ready)
                                : (rsp0_valid_q && rsp0_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_handshake) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state_q == IDLE) && grant_valid && !grant_port;
        req1_ready = (state_q == IDLE) && grant_valid &&  grant_port;
    end

    always_comb begin
        alu_op1_d    = alu_op1_q;
        alu_op2_d    = alu_op2_q;
        alu_sel_d    = alu_sel_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp0_res_d   = rsp0_res_q;
        rsp1_res_d   = rsp1_res_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_op1_d    = grant_port ? req1_op1 : req0_op1;
                    alu_op2_d    = grant_port ? req1_op2 : req0_op2;
                    alu_sel_d    = grant_port ? req1_sel : req0_sel;
                    owner_d      = grant_port;
                    last_grant_d = grant_port;
                end
            end
            EXEC: begin
                if (owner_q) begin
                    rsp1_res_d   = alu_res;
                    rsp1_valid_d = 1'b1;
                end else begin
                    rsp0_res_d   = alu_res;
                    rsp0_valid_d = 1'b1;
                end
            end
            RESP: begin
                if (rsp_handshake) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // last_grant resets to 1 so that port 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            alu_sel_q    <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_res_q   <= '0;
            rsp1_res_q   <= '0;
        end else begin
            alu_op1_q    <= alu_op1_d;
            alu_op2_q    <= alu_op2_d;
            alu_sel_q    <= alu_sel_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_res_q   <= rsp0_res_d;
            rsp1_res_q   <= rsp1_res_d;
        end
    end

    assign alu_op1    = alu_op1_q;
    assign alu_op2    = alu_op2_q;
    assign alu_sel    = alu_sel_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_res   = rsp0_res_q;
    assign rsp1_res   = rsp1_res_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a behavioural ALU drives alu_res, and a transaction-level
// model of round-robin arbitration predicts grants, results and handshakes.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
    logic [4:0]  req0_sel = '0, req1_sel = '0;
    logic [31:0] alu_op1, alu_op2, alu_res;
    logic [4:0]  alu_sel;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0] rsp0_res, rsp1_res;

    int n_checks = 0;
    int n_pass   = 0;

    bit          model_last;
    logic [31:0] model_res [2];

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(32), .SEL_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_sel(req1_sel),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel), .alu_res(alu_res),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(rsp0_res),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(rsp1_res)
    );

    // Stand-in for the shared ALU; codes 19..31 are unsupported and yield 0.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] s);
        case (s)
            5'd0:    return a & b;
            5'd1:    return a | b;
            5'd2:    return a ^ b;
            5'd3:    return ~(a | b);
            5'd4:    return a & ~b;
            5'd5:    return a | ~b;
            5'd6:    return ~(a ^ b);
            5'd7:    return a;
            5'd8:    return b;
            5'd9:    return a + b;
            5'd10:   return a - b;
            5'd11:   return {31'd0, $signed(a) < $signed(b)};
            5'd12:   return {31'd0, a == b};
            5'd13:   return {31'd0, a < b};
            5'd14:   return a << b[4:0];
            5'd15:   return a >> b[4:0];
            5'd16:   return $signed(a) >>> b[4:0];
            5'd17:   return ($signed(a) < $signed(b)) ? a : b;
            5'd18:   return (a > b) ? a : b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_res = alu_fn(alu_op1, alu_op2, alu_sel);

    function automatic bit model_grant(input bit v0, input bit v1);
        if (v0 && v1) return ~model_last;
        return v1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic checkIdleReady(input string tag);
        bit g;
        g = model_grant(req0_valid, req1_valid);
        checkOutput({tag, " idle req0_ready"}, {31'd0, req0_ready}, {31'd0, req0_valid && !g});
        checkOutput({tag, " idle req1_ready"}, {31'd0, req1_ready}, {31'd0, req1_valid && g});
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " alu_op1"}, alu_op1, 32'd0);
        checkOutput({tag, " alu_op2"}, alu_op2, 32'd0);
        checkOutput({tag, " alu_sel"}, {27'd0, alu_sel}, 32'd0);
        checkOutput({tag, " rsp0_valid"}, {31'd0, rsp0_valid}, 32'd0);
        checkOutput({tag, " rsp1_valid"}, {31'd0, rsp1_valid}, 32'd0);
        checkOutput({tag, " rsp0_res"}, rsp0_res, 32'd0);
        checkOutput({tag, " rsp1_res"}, rsp1_res, 32'd0);
    endtask

    task automatic applyReset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_last   = 1'b1;
        model_res[0] = '0;
        model_res[1] = '0;
        @(posedge clk);
        #1;
    endtask

    // One complete transaction from an IDLE cycle; leaves the bench at posedge+1 back in IDLE.
    task automatic applyStimulus(input string tag, input bit v0, input bit v1,
                                 input logic [31:0] a0, input logic [31:0] b0, input logic [4:0] s0,
                                 input logic [31:0] a1, input logic [31:0] b1, input logic [4:0] s1,
                                 input int hold);
        bit          g;
        logic [31:0] ea, eb, er;
        logic [4:0]  es;
        req0_valid = v0; req0_op1 = a0; req0_op2 = b0; req0_sel = s0;
        req1_valid = v1; req1_op1 = a1; req1_op2 = b1; req1_sel = s1;
        rsp0_ready = (hold == 0);
        rsp1_ready = (hold == 0);
        #1;
        g  = model_grant(v0, v1);
        ea = g ? a1 : a0;
        eb = g ? b1 : b0;
        es = g ? s1 : s0;
        er = alu_fn(ea, eb, es);
        checkIdleReady(tag);
        @(posedge clk);
        #1;
        model_last = g;
        checkOutput({tag, " exec alu_op1"}, alu_op1, ea);
        checkOutput({tag, " exec alu_op2"}, alu_op2, eb);
        checkOutput({tag, " exec alu_sel"}, {27'd0, alu_sel}, {27'd0, es});
        checkOutput({tag, " exec readies"}, {30'd0, req1_ready, req0_ready}, 32'd0);
        checkOutput({tag, " exec rsp valids"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        @(posedge clk);
        #1;
        model_res[g] = er;
        for (int c = 0; c <= hold; c++) begin
            checkOutput({tag, " resp rsp valids"}, {30'd0, rsp1_valid, rsp0_valid},
                        g ? 32'd2 : 32'd1);
            checkOutput({tag, " resp rsp0_res"}, rsp0_res, model_res[0]);
            checkOutput({tag, " resp rsp1_res"}, rsp1_res, model_res[1]);
            checkOutput({tag, " resp readies"}, {30'd0, req1_ready, req0_ready}, 32'd0);
            if (c < hold) begin
                @(posedge clk);
                #1;
            end
        end
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, " done rsp valids"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        checkOutput({tag, " done alu_op1 held"}, alu_op1, ea);
        checkOutput({tag, " done alu_sel held"}, {27'd0, alu_sel}, {27'd0, es});
        checkIdleReady({tag, " post"});
    endtask

    initial begin
        logic [31:0] ra [2];
        logic [31:0] rb [2];
        logic [4:0]  rs [2];
        logic [31:0] saved_op1;
        bit          rv0, rv1;

        $display("[TB] starting");
        model_last   = 1'b1;
        model_res[0] = '0;
        model_res[1] = '0;
        #1;
        checkResetValues("power-on");
        applyReset();

        applyStimulus("t1 add", 1, 0, 32'd5, 32'd7, 5'd9, 32'd0, 32'd0, 5'd0, 0);
        checkOutput("t1 rsp0_res value", rsp0_res, 32'd12);

        applyReset();
        applyStimulus("t2 p0 sub", 1, 1, 32'd10, 32'd3, 5'd10, 32'd1, 32'd2, 5'd13, 0);
        checkOutput("t2 rsp0_res value", rsp0_res, 32'd7);
        applyStimulus("t2 p1 sltu", 0, 1, 32'd10, 32'd3, 5'd10, 32'd1, 32'd2, 5'd13, 0);
        checkOutput("t2 rsp1_res value", rsp1_res, 32'd1);

        for (int p = 0; p < 2; p++) begin
            ra[p] = $urandom; rb[p] = $urandom; rs[p] = 5'($urandom_range(0, 18));
        end
        for (int i = 0; i < 8; i++) begin
            bit g;
            g = model_grant(1'b1, 1'b1);
            checkOutput("t3 alternation", {31'd0, g}, {31'd0, i[0]});
            applyStimulus("t3 contend", 1, 1, ra[0], rb[0], rs[0], ra[1], rb[1], rs[1], 0);
            ra[g] = $urandom; rb[g] = $urandom; rs[g] = 5'($urandom_range(0, 18));
        end

        applyStimulus("t4 backpressure", 1, 1, 32'hFFFF_FFFF, 32'd1, 5'd9,
                      ra[1], rb[1], rs[1], 5);
        checkOutput("t4 rsp0_res value", rsp0_res, 32'd0);
        applyStimulus("t4 p1 follow", 0, 1, 32'd0, 32'd0, 5'd0, ra[1], rb[1], rs[1], 0);

        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op1 = 32'h8000_0000; req1_op2 = 32'd4; req1_sel = 5'd16;
        #1;
        checkOutput("t5 req1_ready", {31'd0, req1_ready}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("t5 exec alu_sel", {27'd0, alu_sel}, 32'd16);
        req1_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkResetValues("t5 async reset");
        #2;
        rst_n = 1'b1;
        model_last   = 1'b1;
        model_res[0] = '0;
        model_res[1] = '0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            checkOutput("t5 no rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        end

        applyStimulus("t6 bad sel", 1, 0, 32'h1234, 32'h1234, 5'd31, 32'd0, 32'd0, 5'd0, 0);
        checkOutput("t6 rsp0_res value", rsp0_res, 32'd0);

        saved_op1  = alu_op1;
        req0_valid = 1'b1; req0_op1 = 32'hDEAD_BEEF;
        #1;
        checkOutput("drop req0_ready", {31'd0, req0_ready}, 32'd1);
        req0_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("drop not latched", alu_op1, saved_op1);
        checkOutput("drop no response", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            rv0 = $urandom_range(0, 1);
            rv1 = rv0 ? bit'($urandom_range(0, 1)) : 1'b1;
            applyStimulus("rand", rv0, rv1,
                          $urandom, $urandom, 5'($urandom_range(0, 31)),
                          $urandom, $urandom, 5'($urandom_range(0, 31)),
                          $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
